// File: rtl/image_stream_tx.sv
// image_stream_tx
// Frame-buffered pixel transmitter feeding the streaming pixel input of the
// conv/pooling + DNN top. The host loads one ImageWidth x ImageWidth frame
// into a local register buffer while the block is idle. On start, the frame
// is replayed in raster order under the CNN ready handshake. The block leaves
// at least CyclesPerPixel cycles between an accepted pixel and the next valid
// pixel, marks the final pixel and pulses frame_done when the frame is out.
//
// Ports:
//   clk        in   rising-edge clock
//   res        in   synchronous active-high reset
//   wr_en      in   host write strobe (honoured only while idle)
//   wr_addr    in   raster index of written pixel (row*ImageWidth+col)
//   wr_data    in   pixel value
//   start      in   begin transmitting the buffered frame (level, idle only)
//   in_ready   in   CNN ready
//   out_valid  out  pixel valid (registered)
//   out_data   out  pixel data (registered)
//   out_last   out  high with the final pixel of the frame (registered)
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last pixel is accepted
module image_stream_tx #(
  parameter int BitSize        = 32,
  parameter int ImageWidth     = 8,
  parameter int CyclesPerPixel = 2,
  localparam int NumPix        = ImageWidth * ImageWidth,
  localparam int AddrW         = (NumPix > 1) ? $clog2(NumPix) : 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               wr_en,
  input  logic [AddrW-1:0]   wr_addr,
  input  logic [BitSize-1:0] wr_data,
  input  logic               start,
  input  logic               in_ready,
  output logic               out_valid,
  output logic [BitSize-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               frame_done
);

  localparam int GcntW = $clog2(CyclesPerPixel) + 1;
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NumPix - 1);
  localparam logic [GcntW-1:0] GapLoad = GcntW'(CyclesPerPixel - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   idx_q, idx_d;
  logic [GcntW-1:0]   gcnt_q, gcnt_d;
  logic               valid_q, valid_d;
  logic [BitSize-1:0] data_q, data_d;
  logic               last_q, last_d;

  logic [BitSize-1:0] mem_q [NumPix];

  logic               xfer;
  logic [AddrW-1:0]   idx_inc;

  // Frame buffer: intentionally not reset, so a loaded frame survives res.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign xfer    = valid_q && in_ready;
  assign idx_inc = idx_q + AddrW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
        if (start) begin
          // mem_q is read before any same-cycle write lands, so pixel 0
          // carries the pre-write value.
          idx_d   = '0;
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = mem_q[0];
          last_d  = (NumPix == 1);
        end
      end

      SEND: begin
        if (xfer) begin
          if (idx_q == LastIdx) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else if (CyclesPerPixel == 1) begin
            idx_d  = idx_inc;
            data_d = mem_q[idx_inc];
            last_d = (idx_inc == LastIdx);
          end else begin
            valid_d = 1'b0;
            gcnt_d  = GapLoad;
            idx_d   = idx_inc;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        // Reloading on gcnt==1 puts the next valid exactly CyclesPerPixel
        // cycles after the previous transfer.
        gcnt_d = gcnt_q - GcntW'(1);
        if (gcnt_q == GcntW'(1)) begin
          valid_d = 1'b1;
          data_d  = mem_q[idx_q];
          last_d  = (idx_q == LastIdx);
          state_d = SEND;
        end
      end

      DONE: begin
        data_d  = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_last   = last_q;
  assign busy       = (state_q == SEND) || (state_q == GAP);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_image_stream_tx.sv
module tb_image_stream_tx;

  localparam int BS = 32;
  localparam int IW = 8;
  localparam int NP = IW * IW;

  logic          clk = 1'b0;
  logic          res;
  logic          wr_en_a, wr_en_b;
  logic [5:0]    wr_addr;
  logic [BS-1:0] wr_data;
  logic          start_a, start_b;
  logic          in_ready;

  logic          a_valid, a_last, a_busy, a_done;
  logic [BS-1:0] a_data;
  logic          b_valid, b_last, b_busy, b_done;
  logic [BS-1:0] b_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  image_stream_tx #(.BitSize(BS), .ImageWidth(IW), .CyclesPerPixel(2)) u_dut_a (
    .clk        (clk),
    .res        (res),
    .wr_en      (wr_en_a),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start_a),
    .in_ready   (in_ready),
    .out_valid  (a_valid),
    .out_data   (a_data),
    .out_last   (a_last),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  image_stream_tx #(.BitSize(BS), .ImageWidth(IW), .CyclesPerPixel(1)) u_dut_b (
    .clk        (clk),
    .res        (res),
    .wr_en      (wr_en_b),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start_b),
    .in_ready   (in_ready),
    .out_valid  (b_valid),
    .out_data   (b_data),
    .out_last   (b_last),
    .busy       (b_busy),
    .frame_done (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One frame on the CyclesPerPixel=2 instance.
  // stall_at: pixel held 5 cycles with in_ready low; res_at: pixel where res
  // aborts the frame; hit_at: pixel where start and a write are attempted;
  // hold: leave start high so the next frame follows immediately.
  task automatic run_a(input int tst, input int stall_at, input int res_at,
                       input int hit_at, input bit hold);
    start_a = 1'b1;
    tick();
    if (!hold) start_a = 1'b0;
    chk($sformatf("t%0d busy_at_start", tst), a_busy, 1);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("t%0d px%0d valid", tst, p), a_valid, 1);
      chk($sformatf("t%0d px%0d data", tst, p), a_data, 100 + p);
      chk($sformatf("t%0d px%0d last", tst, p), a_last, (p == NP - 1));
      if (p == res_at) begin
        res = 1'b1;
        tick();
        res = 1'b0;
        chk($sformatf("t%0d rst valid", tst), a_valid, 0);
        chk($sformatf("t%0d rst data", tst), a_data, 0);
        chk($sformatf("t%0d rst last", tst), a_last, 0);
        chk($sformatf("t%0d rst busy", tst), a_busy, 0);
        chk($sformatf("t%0d rst done", tst), a_done, 0);
        return;
      end
      if (p == stall_at) begin
        in_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk($sformatf("t%0d stall%0d valid", tst, s), a_valid, 1);
          chk($sformatf("t%0d stall%0d data", tst, s), a_data, 100 + p);
          chk($sformatf("t%0d stall%0d last", tst, s), a_last, 0);
        end
        in_ready = 1'b1;
      end
      if (p == hit_at) begin
        start_a = 1'b1;
        wr_en_a = 1'b1;
        wr_addr = 6'd5;
        wr_data = 32'hDEAD;
      end
      tick();
      if (p == hit_at) begin
        start_a = 1'b0;
        wr_en_a = 1'b0;
      end
      if (p < NP - 1) begin
        chk($sformatf("t%0d gap%0d valid", tst, p), a_valid, 0);
        chk($sformatf("t%0d gap%0d busy", tst, p), a_busy, 1);
        tick();
      end else begin
        chk($sformatf("t%0d done pulse", tst), a_done, 1);
        chk($sformatf("t%0d done busy", tst), a_busy, 0);
        chk($sformatf("t%0d done valid", tst), a_valid, 0);
        tick();
        chk($sformatf("t%0d idle done", tst), a_done, 0);
        chk($sformatf("t%0d idle valid", tst), a_valid, 0);
        chk($sformatf("t%0d idle busy", tst), a_busy, 0);
      end
    end
  endtask

  // One frame on the CyclesPerPixel=1 instance: pixels every cycle.
  task automatic run_b(input int tst);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("t%0d b px%0d valid", tst, p), b_valid, 1);
      chk($sformatf("t%0d b px%0d data", tst, p), b_data, 100 + p);
      chk($sformatf("t%0d b px%0d last", tst, p), b_last, (p == NP - 1));
      tick();
    end
    chk($sformatf("t%0d b done pulse", tst), b_done, 1);
    chk($sformatf("t%0d b done valid", tst), b_valid, 0);
    chk($sformatf("t%0d b done busy", tst), b_busy, 0);
    tick();
    chk($sformatf("t%0d b idle done", tst), b_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res      = 1'b1;
    wr_en_a  = 1'b0;
    wr_en_b  = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_ready = 1'b1;
    tick();
    tick();
    chk("rst a valid", a_valid, 0);
    chk("rst a data", a_data, 0);
    chk("rst a last", a_last, 0);
    chk("rst a busy", a_busy, 0);
    chk("rst a done", a_done, 0);
    chk("rst b valid", b_valid, 0);
    chk("rst b busy", b_busy, 0);
    res = 1'b0;
    tick();

    for (int i = 0; i < NP; i++) begin
      wr_en_a = 1'b1;
      wr_en_b = 1'b1;
      wr_addr = 6'(i);
      wr_data = 32'(i + 100);
      tick();
    end
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    tick();

    run_a(1, -1, -1, -1, 1'b0);
    run_a(2, 10, -1, -1, 1'b0);
    run_b(3);
    run_a(4, -1, -1, 20, 1'b0);
    run_a(4, -1, -1, -1, 1'b0);
    run_a(5, -1, 30, -1, 1'b0);
    run_a(5, -1, -1, -1, 1'b0);
    run_a(6, -1, -1, -1, 1'b1);
    run_a(6, -1, -1, -1, 1'b0);

    // Write to pixel 0 in the cycle start is accepted.
    start_a = 1'b1;
    wr_en_a = 1'b1;
    wr_addr = 6'd0;
    wr_data = 32'd999;
    tick();
    start_a = 1'b0;
    wr_en_a = 1'b0;
    chk("t7 px0 prewrite", a_data, 100);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("t7 rst valid", a_valid, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t7 px0 postwrite", a_data, 999);
    chk("t7 px0 valid", a_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
